cordic_vector_sequencer: RTL

Iterative CORDIC vectoring-mode engine that owns the x/y/z iteration registers and sequences the per-iteration y-update, x-update and angle-accumulate steps. On `start` it loads an input vector and runs `ITERATIONS` micro-rotations, one per clock, steering y toward zero. It then reports the scaled magnitude (`x_out`) and the angle (`z_out`). It sits between the vector source and downstream consumers, and replaces manual testbench-driven sequencing of the y/x calculators.

---
 rtl/cordic_vector_sequencer_pkg.sv | 50 +++++
 rtl/cordic_atan_rom.sv | 15 +
 rtl/cordic_vector_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cordic_vector_sequencer_pkg.sv
// Shared CORDIC constants: FSM state encoding, pi and the atan(2^-i) table in Q3.29.
package cordic_vector_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] PI_Q29       = 32'h6487ED51;
  localparam int          ATAN_ENTRIES = 28;

  // round(atan(2^-i) * 2^29); from i=10 on the value is exactly 2^(29-i) after rounding
  function automatic logic [31:0] atan_q29(input logic [4:0] i);
    logic [31:0] v;
    case (i)
      5'd0:    v = 32'h1921FB54;
      5'd1:    v = 32'h0ED63383;
      5'd2:    v = 32'h07D6DD7E;
      5'd3:    v = 32'h03FAB753;
      5'd4:    v = 32'h01FF55BB;
      5'd5:    v = 32'h00FFEAAE;
      5'd6:    v = 32'h007FFD55;
      5'd7:    v = 32'h003FFFAB;
      5'd8:    v = 32'h001FFFF5;
      5'd9:    v = 32'h000FFFFF;
      5'd10:   v = 32'h00080000;
      5'd11:   v = 32'h00040000;
      5'd12:   v = 32'h00020000;
      5'd13:   v = 32'h00010000;
      5'd14:   v = 32'h00008000;
      5'd15:   v = 32'h00004000;
      5'd16:   v = 32'h00002000;
      5'd17:   v = 32'h00001000;
      5'd18:   v = 32'h00000800;
      5'd19:   v = 32'h00000400;
      5'd20:   v = 32'h00000200;
      5'd21:   v = 32'h00000100;
      5'd22:   v = 32'h00000080;
      5'd23:   v = 32'h00000040;
      5'd24:   v = 32'h00000020;
      5'd25:   v = 32'h00000010;
      5'd26:   v = 32'h00000008;
      5'd27:   v = 32'h00000004;
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) lookup in Q3.29; indices beyond the table return 0.
module cordic_atan_rom
  import cordic_vector_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       idx,
  output logic [WIDTH-1:0] angle
);

  always_comb begin
    angle = WIDTH'(atan_q29(idx));
  end

endmodule

// File: rtl/cordic_vector_sequencer.sv
// Iterative CORDIC vectoring: start -> done in ITERATIONS+1 cycles, start ignored while busy.
// Optional quadrant pre-correction at load when CORDIC_QUAD_CORR_EN is defined.
module cordic_vector_sequencer
  import cordic_vector_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] z_out
);

  localparam logic [4:0]       LAST_ITER = 5'(ITERATIONS - 1);
  localparam logic [WIDTH-1:0] PI_W      = WIDTH'(PI_Q29);

  state_t state, state_next;
  logic   load, step, publish;

  logic [4:0]              iter;
  logic signed [WIDTH-1:0] x_reg, y_reg, z_reg;
  logic signed [WIDTH-1:0] x_sh, y_sh;
  logic [WIDTH-1:0]        atan_val;
  logic [WIDTH-1:0]        x_load, y_load, z_load;
  logic                    d;

  cordic_atan_rom #(.WIDTH(WIDTH)) u_atan_rom (
    .idx   (iter),
    .angle (atan_val)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    publish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_ITER;
        end
      end
      ST_ITER: begin
        step = 1'b1;
        if (iter == LAST_ITER) state_next = ST_DONE;
      end
      ST_DONE: begin
        publish    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_comb begin
`ifdef CORDIC_QUAD_CORR_EN
    // Left half-plane: rotate by pi so the iterations only ever see x >= 0
    if (x_in[WIDTH-1]) begin
      x_load = -x_in;
      y_load = -y_in;
      z_load = y_in[WIDTH-1] ? -PI_W : PI_W;
    end else begin
      x_load = x_in;
      y_load = y_in;
      z_load = '0;
    end
`else
    x_load = x_in;
    y_load = y_in;
    z_load = '0;
`endif
  end

  // All three updates read the same pre-update x and y
  assign x_sh = x_reg >>> iter;
  assign y_sh = y_reg >>> iter;
  assign d    = ~y_reg[WIDTH-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      x_reg <= '0;
      y_reg <= '0;
      z_reg <= '0;
      iter  <= '0;
      done  <= 1'b0;
      x_out <= '0;
      z_out <= '0;
    end else begin
      done <= publish;
      if (load) begin
        x_reg <= x_load;
        y_reg <= y_load;
        z_reg <= z_load;
        iter  <= '0;
      end else if (step) begin
        if (d) begin
          y_reg <= y_reg - x_sh;
          x_reg <= x_reg + y_sh;
          z_reg <= z_reg + atan_val;
        end else begin
          y_reg <= y_reg + x_sh;
          x_reg <= x_reg - y_sh;
          z_reg <= z_reg - atan_val;
        end
        if (iter != LAST_ITER) iter <= iter + 5'd1;
      end
      if (publish) begin
        x_out <= x_reg;
        z_out <= z_reg;
      end
    end
  end

endmodule
